// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory bus types and RAM defaults
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2
    } ram_fsm_t;

    localparam int RAM_LAT_DEFAULT     = 2;
    localparam int RAM_DEPTH_W_DEFAULT = 14;

    // Anything above the word array's byte span must be zero.
    function automatic logic addr_in_range(input word_t addr, input int depth_w);
        return (addr >> (depth_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - synchronous-write, asynchronous-read word array
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_W = RAM_DEPTH_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               wen,
    input  logic [DEPTH_W-1:0] widx,
    input  word_t              wdata,
    input  logic [DEPTH_W-1:0] ridx,
    output word_t              rdata
);

    word_t mem [2**DEPTH_W] = '{default: '0};

    always_ff @(posedge CLK) begin
        if (wen) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - RAM-side bus responder with programmable access latency
// Optional: RAM_MISALIGN_ERR_EN makes ramaddr[1:0] != 0 an illegal request.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT     = RAM_LAT_DEFAULT,
    parameter int DEPTH_W = RAM_DEPTH_W_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT >= 2) ? LAT - 2 : 0);

    ram_fsm_t           state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    word_t              lat_addr, lat_addr_n;
    logic               lat_wr, lat_wr_n;
    logic               req, misalign, illegal, valid, match, mem_wen;
    logic [DEPTH_W-1:0] idx;
    word_t              rdata;

    assign idx = ramaddr[DEPTH_W+1:2];
    assign req = ramREN | ramWEN;

`ifdef RAM_MISALIGN_ERR_EN
    assign misalign = (ramaddr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign illegal = (ramREN & ramWEN) | (req & (~addr_in_range(ramaddr, DEPTH_W) | misalign));
    assign valid   = req & ~illegal;
    // The initiator must hold the exact same request for the whole transaction.
    assign match   = valid & (ramaddr == lat_addr) & (ramWEN == lat_wr);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lat_addr <= lat_addr_n;
            lat_wr   <= lat_wr_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_addr_n = lat_addr;
        lat_wr_n   = lat_wr;
        ramstate   = FREE;
        ramload    = '0;
        mem_wen    = 1'b0;

        if (illegal) begin
            ramstate = ERROR;
            state_n  = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (valid) begin
                        ramstate   = BUSY;
                        lat_addr_n = ramaddr;
                        lat_wr_n   = ramWEN;
                        if (LAT == 1) begin
                            state_n = S_ACC;
                        end else begin
                            state_n = S_WAIT;
                            cnt_n   = CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    ramstate = BUSY;
                    if (!match) begin
                        state_n = S_IDLE;
                    end else if (cnt == '0) begin
                        state_n = S_ACC;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_ACC: begin
                    state_n = S_IDLE;
                    if (match) begin
                        ramstate = ACCESS;
                        if (lat_wr) begin
                            mem_wen = 1'b1;
                        end else begin
                            ramload = rdata;
                        end
                    end else begin
                        ramstate = BUSY;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Reset dominates the bus outputs and blocks any commit in flight.
        if (!nRST) begin
            ramstate = FREE;
            ramload  = '0;
            mem_wen  = 1'b0;
        end
    end

    ram_array #(
        .DEPTH_W(DEPTH_W)
    ) u_ram_array (
        .CLK   (CLK),
        .wen   (mem_wen),
        .widx  (idx),
        .wdata (ramstore),
        .ridx  (idx),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int LAT = RAM_LAT_DEFAULT;
    localparam int DW  = RAM_DEPTH_W_DEFAULT;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    int checks = 0;
    int errors = 0;

    ram_responder #(.LAT(LAT), .DEPTH_W(DW)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a transaction is an accepted request plus its age in cycles.
    bit    m_active = 0;
    word_t m_addr   = '0;
    bit    m_wr     = 0;
    int    m_age    = 0;
    word_t mmem [int];

    function automatic word_t mem_rd(input int ix);
        return mmem.exists(ix) ? mmem[ix] : '0;
    endfunction

    task automatic model(input logic rn, r, w, input word_t a, d,
                         output ramstate_t es, output word_t el);
        bit req, inr, mis, bad, same;
        longint unsigned span;
        span = longint'(1) << (DW + 2);
        req  = r | w;
        inr  = longint'(a) < span;
`ifdef RAM_MISALIGN_ERR_EN
        mis  = (a % 4) != 0;
`else
        mis  = 0;
`endif
        bad  = (r && w) || (req && (!inr || mis));
        same = req && !bad && a == m_addr && w == m_wr;
        el   = '0;
        if (!rn) begin
            es       = FREE;
            m_active = 0;
        end else if (bad) begin
            es       = ERROR;
            m_active = 0;
        end else if (!m_active) begin
            if (req) begin
                es       = BUSY;
                m_active = 1;
                m_addr   = a;
                m_wr     = w;
                m_age    = 0;
            end else begin
                es = FREE;
            end
        end else begin
            m_age++;
            if (m_age < LAT) begin
                es = BUSY;
                if (!same) m_active = 0;
            end else begin
                m_active = 0;
                if (same) begin
                    es = ACCESS;
                    if (m_wr) mmem[int'(a / 4)] = d;
                    else      el = mem_rd(int'(a / 4));
                end else begin
                    es = BUSY;
                end
            end
        end
    endtask

    task automatic cyc(input logic rn, r, w, input word_t a, d,
                       output ramstate_t es, output word_t el);
        @(negedge CLK);
        nRST = rn; ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
        #2;
        model(rn, r, w, a, d, es, el);
    endtask

    task automatic chk(input string nm, input ramstate_t es, input word_t el);
        checks++;
        if (ramstate !== es) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", nm, ramstate, es);
        end
        checks++;
        if (ramload !== el) begin
            errors++;
            $display("FAIL %s load: got %h expected %h", nm, ramload, el);
        end
    endtask

    typedef struct {
        logic      ren;
        logic      wen;
        word_t     addr;
        word_t     data;
        ramstate_t st;
        word_t     ld;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, w, input word_t a, d,
                               input ramstate_t s, input word_t l);
        vec_t x;
        x = '{r, w, a, d, s, l};
        return x;
    endfunction

    initial begin
        ramstate_t es;
        word_t     el;
        word_t     addrs [6];
        logic      r, w;
        word_t     a;
        logic      rn;
        int        k;

        // Write 0x40, read it back
        tbl.push_back(v(0, 1, 32'h40, 32'hDEADBEEF, BUSY,   '0));
        tbl.push_back(v(0, 1, 32'h40, 32'hDEADBEEF, BUSY,   '0));
        tbl.push_back(v(0, 1, 32'h40, 32'hDEADBEEF, ACCESS, '0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        FREE,   '0));
        tbl.push_back(v(1, 0, 32'h40, 32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h40, 32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h40, 32'h0,        ACCESS, 32'hDEADBEEF));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        FREE,   '0));
        // Illegal REN&WEN at 0x8, then mem[0x8] still zero
        tbl.push_back(v(1, 1, 32'h8,  32'h12345678, ERROR,  '0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        FREE,   '0));
        tbl.push_back(v(1, 0, 32'h8,  32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h8,  32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h8,  32'h0,        ACCESS, '0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        FREE,   '0));
        // Seed 0x104, then read 0x100 switched to 0x104 mid-wait
        tbl.push_back(v(0, 1, 32'h104, 32'hCAFEF00D, BUSY,   '0));
        tbl.push_back(v(0, 1, 32'h104, 32'hCAFEF00D, BUSY,   '0));
        tbl.push_back(v(0, 1, 32'h104, 32'hCAFEF00D, ACCESS, '0));
        tbl.push_back(v(0, 0, 32'h0,   32'h0,        FREE,   '0));
        tbl.push_back(v(1, 0, 32'h100, 32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h104, 32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h104, 32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h104, 32'h0,        BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h104, 32'h0,        ACCESS, 32'hCAFEF00D));
        tbl.push_back(v(0, 0, 32'h0,   32'h0,        FREE,   '0));
        // Out-of-range: ERROR only when a request is present
        tbl.push_back(v(1, 0, 32'h10000, 32'h0,      ERROR,  '0));
        tbl.push_back(v(0, 0, 32'h10000, 32'h0,      FREE,   '0));
        tbl.push_back(v(0, 1, 32'h80000040, 32'h1,   ERROR,  '0));
        tbl.push_back(v(0, 0, 32'h0,   32'h0,        FREE,   '0));
        // Misaligned read of 0x42
`ifdef RAM_MISALIGN_ERR_EN
        tbl.push_back(v(1, 0, 32'h42, 32'h0, ERROR,  '0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0, FREE,   '0));
`else
        tbl.push_back(v(1, 0, 32'h42, 32'h0, BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h42, 32'h0, BUSY,   '0));
        tbl.push_back(v(1, 0, 32'h42, 32'h0, ACCESS, 32'hDEADBEEF));
        tbl.push_back(v(0, 0, 32'h0,  32'h0, FREE,   '0));
`endif

        nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;

        // Reset holds FREE even with a request present
        cyc(0, 1, 0, 32'h40, 0, es, el); chk("reset_req", FREE, '0);
        cyc(0, 0, 0, 32'h0,  0, es, el); chk("reset_idle", FREE, '0);
        cyc(1, 0, 0, 32'h0,  0, es, el); chk("post_reset0", FREE, '0);
        cyc(1, 0, 0, 32'h0,  0, es, el); chk("post_reset1", FREE, '0);

        foreach (tbl[i]) begin
            cyc(1, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].data, es, el);
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].ld);
        end

        // Write aborted by reset in the wait cycle
        cyc(1, 0, 1, 32'h20, 32'hA5A5A5A5, es, el); chk("seed20_0", BUSY, '0);
        cyc(1, 0, 1, 32'h20, 32'hA5A5A5A5, es, el); chk("seed20_1", BUSY, '0);
        cyc(1, 0, 1, 32'h20, 32'hA5A5A5A5, es, el); chk("seed20_2", ACCESS, '0);
        cyc(1, 0, 0, 32'h0,  32'h0,        es, el); chk("seed20_idle", FREE, '0);
        cyc(1, 0, 1, 32'h20, 32'h55,       es, el); chk("abort_acc", BUSY, '0);
        cyc(0, 0, 1, 32'h20, 32'h55,       es, el); chk("abort_rst", FREE, '0);
        cyc(0, 0, 1, 32'h20, 32'h55,       es, el); chk("abort_rst2", FREE, '0);
        cyc(1, 0, 0, 32'h0,  32'h0,        es, el); chk("abort_idle", FREE, '0);
        cyc(1, 1, 0, 32'h20, 32'h0,        es, el); chk("rd20_0", BUSY, '0);
        cyc(1, 1, 0, 32'h20, 32'h0,        es, el); chk("rd20_1", BUSY, '0);
        cyc(1, 1, 0, 32'h20, 32'h0,        es, el); chk("rd20_2", ACCESS, 32'hA5A5A5A5);
        cyc(1, 0, 0, 32'h0,  32'h0,        es, el); chk("rd20_idle", FREE, '0);

        // Randomized traffic against the model
        addrs[0] = 32'h0;  addrs[1] = 32'h4;  addrs[2] = 32'h40;
        addrs[3] = 32'h44; addrs[4] = 32'h41; addrs[5] = word_t'(1) << (DW + 2);
        r = 0; w = 0; a = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 20) begin
                k = $urandom_range(0, 9);
                r = (k <= 3) || (k == 8);
                w = ((k >= 4) && (k <= 7)) || (k == 8);
                a = addrs[$urandom_range(0, 5)];
            end
            rn = ($urandom_range(0, 249) != 0);
            cyc(rn, r, w, a, $urandom, es, el);
            chk($sformatf("rand%0d", i), es, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
